// File: rtl/data_mem_controller_pkg.sv
// data_mem_controller_pkg: channel state enum, width defaults, consumer-index width and saturating-add helpers
package data_mem_controller_pkg;
  localparam int DEFAULT_ADDR_BITS = 8;
  localparam int DEFAULT_DATA_BITS = 8;
  typedef enum logic [2:0] {IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING} channel_state_t;
  function automatic int idx_bits(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input int b);
    int s;
    s = int'(a) + b;
    return s > 65535 ? 16'hFFFF : 16'(s);
  endfunction
endpackage

// File: rtl/data_mem_controller_if.sv
// data_mem_controller_if: N-lane load/store bus; master issues valid/address/write_data, slave returns ready/read_data
interface data_mem_controller_if
  import data_mem_controller_pkg::*;
#(
  parameter int N = 8,
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
  parameter int DATA_BITS = DEFAULT_DATA_BITS
);
  logic [N-1:0] read_valid, read_ready, write_valid, write_ready;
  logic [N-1:0][ADDR_BITS-1:0] read_address, write_address;
  logic [N-1:0][DATA_BITS-1:0] read_data, write_data;
  modport master(output read_valid, read_address, write_valid, write_address, write_data, input read_ready, read_data, write_ready);
  modport slave(input read_valid, read_address, write_valid, write_address, write_data, output read_ready, read_data, write_ready);
endinterface

// File: rtl/data_mem_controller_fsm.sv
// data_mem_controller_fsm: one channel FSM; in clk/reset/grant/consumer valids/mem ready+data, out state/current consumer/address/data
module data_mem_controller_fsm
  import data_mem_controller_pkg::*;
#(
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int IB = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_grant_read,
  input  logic                 i_grant_write,
  input  logic [IB-1:0]        i_grant_idx,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [DATA_BITS-1:0] i_wdata,
  input  logic                 i_read_valid,
  input  logic                 i_write_valid,
  input  logic                 i_mem_read_ready,
  input  logic                 i_mem_write_ready,
  input  logic [DATA_BITS-1:0] i_mem_read_data,
  output channel_state_t       o_state,
  output logic [IB-1:0]        o_cc,
  output logic [ADDR_BITS-1:0] o_addr,
  output logic [DATA_BITS-1:0] o_wdata,
  output logic [DATA_BITS-1:0] o_rdata
);
  channel_state_t r_state, w_next;
  logic [IB-1:0] r_cc;
  logic [ADDR_BITS-1:0] r_addr;
  logic [DATA_BITS-1:0] r_wdata, r_rdata;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:           w_next = i_grant_read ? READ_WAITING : i_grant_write ? WRITE_WAITING : IDLE;
      READ_WAITING:   w_next = i_mem_read_ready ? READ_RELAYING : READ_WAITING;
      WRITE_WAITING:  w_next = i_mem_write_ready ? WRITE_RELAYING : WRITE_WAITING;
      READ_RELAYING:  w_next = i_read_valid ? READ_RELAYING : IDLE;
      WRITE_RELAYING: w_next = i_write_valid ? WRITE_RELAYING : IDLE;
      default:        w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cc <= '0;
      r_addr <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && (i_grant_read || i_grant_write)) begin
        r_cc <= i_grant_idx;
        r_addr <= i_addr;
        r_wdata <= i_wdata;
      end
      if (r_state == READ_WAITING && i_mem_read_ready) r_rdata <= i_mem_read_data;
    end
  end
  assign o_state = r_state;
  assign o_cc = r_cc;
  assign o_addr = r_addr;
  assign o_wdata = r_wdata;
  assign o_rdata = r_rdata;
endmodule

// File: rtl/data_mem_controller.sv
// data_mem_controller: LSU->memory channel arbiter with claim table; ports clk, reset, consumer (slave bus), mem (master bus), perf_* with DATA_MEM_CONTROLLER_PERF_EN
module data_mem_controller
  import data_mem_controller_pkg::*;
#(
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int WRITE_ENABLE = 1
) (
  input logic clk,
  input logic reset,
  data_mem_controller_if.slave consumer,
  data_mem_controller_if.master mem
`ifdef DATA_MEM_CONTROLLER_PERF_EN
  ,
  output logic [15:0] perf_reads,
  output logic [15:0] perf_writes,
  output logic [15:0] perf_stall_cycles
`endif
);
  localparam int IB = idx_bits(NUM_CONSUMERS);
  channel_state_t w_state [NUM_CHANNELS];
  logic [IB-1:0] w_cc [NUM_CHANNELS];
  logic [IB-1:0] w_gidx [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] w_addr [NUM_CHANNELS];
  logic [DATA_BITS-1:0] w_wdata [NUM_CHANNELS];
  logic [DATA_BITS-1:0] w_rdata [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] w_gr, w_gw;
  logic [NUM_CONSUMERS-1:0] r_claim, w_taken, w_clr, w_rreq, w_wreq;
  assign w_rreq = consumer.read_valid;
  assign w_wreq = WRITE_ENABLE != 0 ? consumer.write_valid : '0;
  always_comb begin
    w_taken = r_claim;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      w_gr[c] = 1'b0;
      w_gw[c] = 1'b0;
      w_gidx[c] = '0;
      for (int i = 0; i < NUM_CONSUMERS; i++)
        if (w_state[c] == IDLE && !w_gr[c] && !w_gw[c] && !w_taken[i] && (w_rreq[i] || w_wreq[i])) begin
          w_gr[c] = w_rreq[i];
          w_gw[c] = !w_rreq[i];
          w_gidx[c] = IB'(i);
          w_taken[i] = 1'b1;
        end
    end
  end
  always_comb begin
    consumer.read_ready = '0;
    consumer.read_data = '0;
    consumer.write_ready = '0;
    mem.read_valid = '0;
    mem.read_address = '0;
    mem.write_valid = '0;
    mem.write_address = '0;
    mem.write_data = '0;
    w_clr = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      mem.read_valid[c] = w_state[c] == READ_WAITING;
      mem.read_address[c] = mem.read_valid[c] ? w_addr[c] : '0;
      mem.write_valid[c] = WRITE_ENABLE != 0 && w_state[c] == WRITE_WAITING;
      mem.write_address[c] = mem.write_valid[c] ? w_addr[c] : '0;
      mem.write_data[c] = mem.write_valid[c] ? w_wdata[c] : '0;
      if (w_state[c] == READ_RELAYING) begin
        consumer.read_ready[w_cc[c]] = 1'b1;
        consumer.read_data[w_cc[c]] = w_rdata[c];
        w_clr[w_cc[c]] = !consumer.read_valid[w_cc[c]];
      end
      if (WRITE_ENABLE != 0 && w_state[c] == WRITE_RELAYING) begin
        consumer.write_ready[w_cc[c]] = 1'b1;
        w_clr[w_cc[c]] = !consumer.write_valid[w_cc[c]];
      end
    end
  end
  always_ff @(posedge clk) r_claim <= reset ? '0 : w_taken & ~w_clr;
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    data_mem_controller_fsm #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .IB(IB)) u_fsm (
      .clk(clk),
      .reset(reset),
      .i_grant_read(w_gr[c]),
      .i_grant_write(w_gw[c]),
      .i_grant_idx(w_gidx[c]),
      .i_addr(w_gw[c] ? consumer.write_address[w_gidx[c]] : consumer.read_address[w_gidx[c]]),
      .i_wdata(consumer.write_data[w_gidx[c]]),
      .i_read_valid(consumer.read_valid[w_cc[c]]),
      .i_write_valid(consumer.write_valid[w_cc[c]]),
      .i_mem_read_ready(mem.read_ready[c]),
      .i_mem_write_ready(mem.write_ready[c]),
      .i_mem_read_data(mem.read_data[c]),
      .o_state(w_state[c]),
      .o_cc(w_cc[c]),
      .o_addr(w_addr[c]),
      .o_wdata(w_wdata[c]),
      .o_rdata(w_rdata[c])
    );
  end
`ifdef DATA_MEM_CONTROLLER_PERF_EN
  logic w_stall;
  assign w_stall = |((w_rreq | w_wreq) & ~w_taken);
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_reads <= '0;
      perf_writes <= '0;
      perf_stall_cycles <= '0;
    end else begin
      perf_reads <= sat_add16(perf_reads, $countones(w_gr));
      perf_writes <= sat_add16(perf_writes, $countones(w_gw));
      perf_stall_cycles <= sat_add16(perf_stall_cycles, int'(w_stall));
    end
  end
`endif
endmodule
